// File: rtl/term_key_pkg.sv
// Shared types and byte constants for the terminal key decoder.
package term_key_pkg;

  typedef enum logic [3:0] {
    EV_NONE      = 4'd0,
    EV_CHAR      = 4'd1,
    EV_SPACE     = 4'd2,
    EV_BACKSPACE = 4'd3,
    EV_ENTER     = 4'd4,
    EV_ESC       = 4'd5,
    EV_ALT       = 4'd6,
    EV_UP        = 4'd7,
    EV_DOWN      = 4'd8,
    EV_RIGHT     = 4'd9,
    EV_LEFT      = 4'd10,
    EV_DELETE    = 4'd11,
    EV_UNKNOWN   = 4'd12
  } ev_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ESC   = 3'd1,
    S_CSI   = 3'd2,
    S_TILDE = 3'd3,
    S_SKIP  = 3'd4
  } state_e;

  localparam logic [7:0] ESC    = 8'h1B;
  localparam logic [7:0] CSI_CH = 8'h5B;
  localparam logic [7:0] TILDE  = 8'h7E;
  localparam logic [7:0] BS     = 8'h08;
  localparam logic [7:0] DEL    = 8'h7F;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] SP     = 8'h20;

  // code (4) + data (8)
  localparam int EV_W = 12;

  // CSI final bytes terminate a control sequence
  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/term_key_ev_fifo.sv
// Event FIFO: code+data entries, power-of-two depth, wrap-bit pointers.
module term_key_ev_fifo
  import term_key_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EV_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage needs no reset; the head is only observed while non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // pointer update; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/term_key_decoder.sv
// Terminal key decoder: byte stream in, one key event per completed token out.
// Optional lone-ESC timeout enabled by defining TERM_KEY_ESC_TIMEOUT_EN.
//
//   state   | meaning
//   S_IDLE  | between tokens
//   S_ESC   | ESC received, waiting for '[' or an ALT byte
//   S_CSI   | ESC [ received, waiting for first parameter/final byte
//   S_TILDE | ESC [ 3 received, expecting '~' for delete
//   S_SKIP  | unrecognised CSI, discarding until a final byte
module term_key_decoder
  import term_key_pkg::*;
#(
  parameter int EV_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ev_valid,
  output logic [3:0] ev_code,
  output logic [7:0] ev_data,
  input  logic       ev_ready,
  output logic       busy
);

  state_e            state;
  state_e            state_n;
  logic              accept;
  logic              push;
  ev_e               push_code;
  logic [7:0]        push_data;
  logic [EV_W-1:0]   fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [$clog2(EV_DEPTH):0] unused_count;
  logic              tmo_fire;

  // backpressure stops the parser, so every accepted byte has room for its event
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;

`ifdef TERM_KEY_ESC_TIMEOUT_EN
  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;

  // counter holds at its last value while the FIFO is full so the push retries
  assign tmo_fire = (state == S_ESC) && !accept && (tmo_cnt == TO_LAST) && !fifo_full;

  // count idle cycles spent in S_ESC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (accept || (state != S_ESC) || tmo_fire) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TO_LAST) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  logic unused_tmo_param;
  assign unused_tmo_param = (TIMEOUT_CYCLES > 0);
  assign tmo_fire = 1'b0;
`endif

  // next state and the event produced by the accepted byte (or by a timeout)
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_code = EV_NONE;
    push_data = 8'h00;
    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (in_data == ESC) begin
            state_n = S_ESC;
          end else begin
            push = 1'b1;
            if (in_data == SP) begin
              push_code = EV_SPACE;
            end else if ((in_data == BS) || (in_data == DEL)) begin
              push_code = EV_BACKSPACE;
            end else if (in_data == CR) begin
              push_code = EV_ENTER;
            end else if ((in_data >= 8'h21) && (in_data <= 8'h7E)) begin
              push_code = EV_CHAR;
              push_data = in_data;
            end else begin
              push_code = EV_UNKNOWN;
              push_data = in_data;
            end
          end
        end
        S_ESC: begin
          if (in_data == CSI_CH) begin
            state_n = S_CSI;
          end else if (in_data == ESC) begin
            push      = 1'b1;
            push_code = EV_ESC;
          end else begin
            push      = 1'b1;
            push_code = EV_ALT;
            push_data = in_data;
            state_n   = S_IDLE;
          end
        end
        S_CSI: begin
          case (in_data)
            8'h41: begin push = 1'b1; push_code = EV_UP;    state_n = S_IDLE; end
            8'h42: begin push = 1'b1; push_code = EV_DOWN;  state_n = S_IDLE; end
            8'h43: begin push = 1'b1; push_code = EV_RIGHT; state_n = S_IDLE; end
            8'h44: begin push = 1'b1; push_code = EV_LEFT;  state_n = S_IDLE; end
            8'h33: state_n = S_TILDE;
            default: begin
              if (is_final(in_data)) begin
                push      = 1'b1;
                push_code = EV_UNKNOWN;
                push_data = in_data;
                state_n   = S_IDLE;
              end else begin
                state_n = S_SKIP;
              end
            end
          endcase
        end
        S_TILDE: begin
          if (in_data == TILDE) begin
            push      = 1'b1;
            push_code = EV_DELETE;
            state_n   = S_IDLE;
          end else if ((in_data >= 8'h40) && (in_data <= 8'h7D)) begin
            push      = 1'b1;
            push_code = EV_UNKNOWN;
            push_data = in_data;
            state_n   = S_IDLE;
          end else begin
            state_n = S_SKIP;
          end
        end
        S_SKIP: begin
          if (is_final(in_data)) begin
            push      = 1'b1;
            push_code = EV_UNKNOWN;
            push_data = in_data;
            state_n   = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (tmo_fire) begin
      push      = 1'b1;
      push_code = EV_ESC;
      state_n   = S_IDLE;
    end
  end

  // parser state with busy registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != S_IDLE);
    end
  end

  term_key_ev_fifo #(
    .DEPTH (EV_DEPTH),
    .WIDTH (EV_W)
  ) u_ev_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_code, push_data}),
    .pop       (ev_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = fifo_empty ? 4'(EV_NONE) : fifo_head[11:8];
  assign ev_data  = fifo_empty ? 8'h00 : fifo_head[7:0];

endmodule

// File: tb/tb_term_key_decoder.sv
// Bench for term_key_decoder: token-level reference model plus directed cases.
module tb_term_key_decoder;
  import term_key_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ev_valid;
  logic [3:0] ev_code;
  logic [7:0] ev_data;
  logic       ev_ready = 1'b0;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit rand_rdy = 1'b0;

  logic [11:0] mq[$];
  logic [7:0]  seq[$];
  int          idle_cnt = 0;
  logic [11:0] got[$];

  term_key_decoder #(.EV_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_data(ev_data), .ev_ready(ev_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Classify the bytes of the token collected so far.
  function automatic void classify(input logic [7:0] s[$], output bit done,
                                   output logic [3:0] code, output logic [7:0] data,
                                   output bit rest_esc);
    int n;
    logic [7:0] last;
    n = s.size();
    last = s[n-1];
    done = 1; code = EV_NONE; data = 8'h00; rest_esc = 0;
    if (s[0] != 8'h1B) begin
      if (last == 8'h20) code = EV_SPACE;
      else if (last == 8'h08 || last == 8'h7F) code = EV_BACKSPACE;
      else if (last == 8'h0D) code = EV_ENTER;
      else if (last >= 8'h21 && last <= 8'h7E) begin code = EV_CHAR; data = last; end
      else begin code = EV_UNKNOWN; data = last; end
    end else if (n == 1) done = 0;
    else if (s[1] == 8'h1B) begin code = EV_ESC; rest_esc = 1; end
    else if (s[1] != 8'h5B) begin code = EV_ALT; data = s[1]; end
    else if (n == 2) done = 0;
    else if (s[2] != 8'h33) begin
      if (!(last >= 8'h40 && last <= 8'h7E)) done = 0;
      else if (n == 3 && last >= 8'h41 && last <= 8'h44)
        code = (last == 8'h41) ? EV_UP : (last == 8'h42) ? EV_DOWN :
               (last == 8'h43) ? EV_RIGHT : EV_LEFT;
      else begin code = EV_UNKNOWN; data = last; end
    end else if (n == 3) done = 0;
    else if (n == 4 && last == 8'h7E) code = EV_DELETE;
    else if (n == 4 && last >= 8'h40 && last <= 8'h7D) begin code = EV_UNKNOWN; data = last; end
    else if (n > 4 && last >= 8'h40 && last <= 8'h7E) begin code = EV_UNKNOWN; data = last; end
    else done = 0;
  endfunction

  // reference model: event queue and pending token
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      seq.delete();
      idle_cnt = 0;
    end else begin
      bit full_m, acc, done, rest;
      logic [3:0] c;
      logic [7:0] d;
      full_m = (mq.size() >= DEPTH);
      acc = in_valid && !full_m;
      if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
      if (acc) begin
        seq.push_back(in_data);
        idle_cnt = 0;
        classify(seq, done, c, d, rest);
        if (done) begin
          mq.push_back({c, d});
          seq.delete();
          if (rest) seq.push_back(8'h1B);
        end
      end
`ifdef TERM_KEY_ESC_TIMEOUT_EN
      else if (seq.size() == 1) begin
        idle_cnt++;
        if (idle_cnt >= TMO) begin
          if (!full_m) begin
            mq.push_back({4'(EV_ESC), 8'h00});
            seq.delete();
            idle_cnt = 0;
          end else idle_cnt = TMO;
        end
      end
`endif
    end
  end

  // per-cycle compare against the model; also log popped events
  always @(negedge clk) begin
    if (chk_en) begin
      bit v;
      v = (mq.size() > 0);
      chk("ev_valid", 16'(ev_valid), 16'(v));
      chk("ev_code", 16'(ev_code), v ? 16'(mq[0][11:8]) : 16'h0);
      chk("ev_data", 16'(ev_data), v ? 16'(mq[0][7:0]) : 16'h0);
      chk("in_ready", 16'(in_ready), 16'(mq.size() < DEPTH));
      chk("busy", 16'(busy), 16'(seq.size() > 0));
      if (ev_valid && ev_ready) got.push_back({ev_code, ev_data});
    end
  end

  task automatic send(input logic [7:0] b);
    int k;
    bit acc;
    in_valid = 1'b1;
    in_data = b;
    k = 0;
    forever begin
      if (rand_rdy) ev_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      k++;
      if (k > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL send_stall: byte %0h not accepted within 100 cycles", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rand_rdy) ev_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev_at(input int i, input logic [3:0] c, input logic [7:0] d);
    if (i >= got.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL event%0d: got none expected %0h/%0h", i, c, d);
    end else chk($sformatf("event%0d", i), 16'(got[i]), 16'({c, d}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ev_valid", 16'(ev_valid), 16'h0);
    chk("rst_ev_code", 16'(ev_code), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_busy", 16'(busy), 16'h0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // plain bytes, one event per byte
    ev_ready = 1'b1;
    got.delete();
    send(8'h61);
    chk("t1_lat_valid", 16'(ev_valid), 16'h1);
    chk("t1_lat_code", 16'(ev_code), 16'(EV_CHAR));
    send(8'h20);
    send(8'h0D);
    idle(3);
    ev_at(0, EV_CHAR, 8'h61);
    ev_at(1, EV_SPACE, 8'h00);
    ev_at(2, EV_ENTER, 8'h00);

    // arrow / delete sequences
    got.delete();
    send(8'h1B); chk("t2_busy_a", 16'(busy), 16'h1);
    send(8'h5B); chk("t2_busy_b", 16'(busy), 16'h1);
    send(8'h44); chk("t2_busy_c", 16'(busy), 16'h0);
    send(8'h1B); send(8'h5B); send(8'h43);
    send(8'h1B); send(8'h5B); send(8'h33);
    chk("t2_busy_d", 16'(busy), 16'h1);
    send(8'h7E);
    chk("t2_busy_e", 16'(busy), 16'h0);
    idle(3);
    ev_at(0, EV_LEFT, 8'h00);
    ev_at(1, EV_RIGHT, 8'h00);
    ev_at(2, EV_DELETE, 8'h00);
    chk("t2_count", 16'(got.size()), 16'd3);

    // backpressure with a full FIFO
    got.delete();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h61 + 8'(i));
    chk("t3_full_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b1; in_data = 8'h65;
    @(posedge clk); #1;
    chk("t3_held", 16'(in_ready), 16'h0);
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
    chk("t3_room", 16'(in_ready), 16'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_full_again", 16'(in_ready), 16'h0);
    ev_ready = 1'b1;
    idle(6);
    for (int i = 0; i < 5; i++) ev_at(i, EV_CHAR, 8'h61 + 8'(i));

    // unknown CSI, alt, double escape
    got.delete();
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h3B); send(8'h35); send(8'h48);
    send(8'h1B); send(8'h78);
    send(8'h1B); send(8'h1B);
    chk("t4_esc_busy", 16'(busy), 16'h1);
    send(8'h61);
    idle(3);
    ev_at(0, EV_UNKNOWN, 8'h48);
    ev_at(1, EV_ALT, 8'h78);
    ev_at(2, EV_ESC, 8'h00);
    ev_at(3, EV_ALT, 8'h61);

    // asynchronous reset mid-sequence
    ev_ready = 1'b0;
    send(8'h61); send(8'h62);
    send(8'h1B); send(8'h5B);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 16'(ev_valid), 16'h0);
    chk("t5_busy", 16'(busy), 16'h0);
    chk("t5_code", 16'(ev_code), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b1;
    got.delete();
    send(8'h41);
    idle(2);
    ev_at(0, EV_CHAR, 8'h41);
    chk("t5_count", 16'(got.size()), 16'd1);

`ifdef TERM_KEY_ESC_TIMEOUT_EN
    // lone ESC timeout, and a byte arriving on the expiry cycle
    got.delete();
    send(8'h1B);
    idle(TMO - 1);
    chk("t6_pre_valid", 16'(ev_valid), 16'h0);
    chk("t6_pre_busy", 16'(busy), 16'h1);
    idle(1);
    chk("t6_fire_code", 16'(ev_code), 16'(EV_ESC));
    chk("t6_fire_busy", 16'(busy), 16'h0);
    idle(2);
    send(8'h1B);
    idle(TMO - 1);
    send(8'h62);
    idle(3);
    ev_at(0, EV_ESC, 8'h00);
    ev_at(1, EV_ALT, 8'h62);
    chk("t6_count", 16'(got.size()), 16'd2);
`endif

    // randomized token-biased stream
    rand_rdy = 1'b1;
    repeat (400) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: b = 8'h1B;
        3:       b = 8'h5B;
        4:       b = 8'h33;
        5:       b = 8'h7E;
        6:       b = 8'h41 + 8'($urandom_range(0, 3));
        7:       b = 8'h3B;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) idle(12);
    end
    rand_rdy = 1'b0;
    ev_ready = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/term_key_decoder.md
Name: term_key_decoder

Overview:
- Sequential successor to the combinational terminal-byte classifier.
- Accepts a raw byte stream from the UART receiver with a valid/ready handshake.
- Tracks ANSI escape/CSI state internally, with no externally supplied stage flags.
- Emits one decoded key event per completed token into a parametrised event FIFO, which the line-editor consumes.

Parameters:
- EV_DEPTH, 4, event FIFO depth; power of two, ≥2.
- TIMEOUT_CYCLES, 1024, idle cycles in S_ESC before a lone ESC is reported (used only with ESC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; one clock, no other reset.
- in_valid  in  1  in_data valid.
- in_data  in  8  received byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- ev_valid  out  1  FIFO head valid.
- ev_code  out  4  event code (term_key_pkg::ev_e).
- ev_data  out  8  byte associated with the event (CHAR/ALT/UNKNOWN), else 0.
- ev_ready  in  1  head popped when ev_valid && ev_ready.
- busy  out  1  parser state != S_IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - State → S_IDLE; FIFO emptied; timeout counter cleared.
  - ev_valid=0, ev_code=EV_NONE, ev_data=0, busy=0, in_ready=1.
- Handshake:
  - in_ready = !fifo_full. It does not depend on ev_ready the same cycle.
  - A pop and a push in the same cycle are both honoured; count is unchanged.
- Latency:
  - A byte accepted at edge N is visible as ev_valid at N+1 if the FIFO was empty.
  - ev_code/ev_data are combinational from the FIFO head.
- Each accepted byte produces at most one push.
- S_IDLE:
  - 0x1B → S_ESC, no event.
  - 0x20 → EV_SPACE.
  - 0x08 or 0x7F → EV_BACKSPACE.
  - 0x0D → EV_ENTER.
  - 0x21–0x7E → EV_CHAR, data=byte.
  - Other → EV_UNKNOWN, data=byte.
- S_ESC:
  - '[' (0x5B) → S_CSI.
  - 0x1B → EV_ESC, remain in S_ESC.
  - Other → EV_ALT, data=byte, → S_IDLE.
- S_CSI:
  - 'A' → EV_UP, 'B' → EV_DOWN, 'C' → EV_RIGHT, 'D' → EV_LEFT, each → S_IDLE.
  - '3' → S_TILDE.
  - Other final byte 0x40–0x7E → EV_UNKNOWN, data=byte, → S_IDLE.
  - Any other byte → S_SKIP.
- S_TILDE:
  - '~' → EV_DELETE, → S_IDLE.
  - Other final 0x40–0x7D → EV_UNKNOWN, → S_IDLE.
  - Else → S_SKIP.
- S_SKIP: discard bytes until a final byte 0x40–0x7E → EV_UNKNOWN, data=final, → S_IDLE.
- Backpressure: while FIFO full, no byte is accepted, so state never advances without room for its event.

Optional Feature:
- Macro: TERM_KEY_ESC_TIMEOUT_EN.
- With the macro:
  - A counter increments each cycle in S_ESC with no accepted byte and clears on any accepted byte.
  - On reaching TIMEOUT_CYCLES with FIFO not full: push EV_ESC, → S_IDLE, clear counter.
  - If the FIFO is full at expiry, the counter holds and the push retries each cycle.
  - A byte accepted in the expiry cycle takes priority; no timeout event is pushed that cycle.
- Without the macro: no counter; a lone ESC waits indefinitely and is reported only via ESC ESC or ESC+byte (EV_ALT).

Decomposition:
- term_key_pkg holds:
  - ev_e: 4-bit enum EV_NONE=0, EV_CHAR, EV_SPACE, EV_BACKSPACE, EV_ENTER, EV_ESC, EV_ALT, EV_UP, EV_DOWN, EV_RIGHT, EV_LEFT, EV_DELETE, EV_UNKNOWN.
  - Parser state enum.
  - Byte constants: ESC=0x1B, CSI_CH=0x5B, TILDE=0x7E, BS=0x08, DEL=0x7F, CR=0x0D, SP=0x20.
- Sub-module term_key_ev_fifo:
  - 12-bit wide (code+data), EV_DEPTH deep.
  - Outputs full/empty and count.
  - Registered pointers; extra wrap bit for full/empty.

Test Plan:
- Reset then bytes 0x61, 0x20, 0x0D with ev_ready=1 → events CHAR/0x61, SPACE, ENTER on consecutive cycles, each 1 cycle after acceptance.
- Sequences 1B 5B 44, then 1B 5B 43, then 1B 5B 33 7E → LEFT, RIGHT, DELETE only; busy=1 between bytes of each sequence, 0 after.
- ev_ready=0, push 5 printable bytes with EV_DEPTH=4 → in_ready drops after the 4th; 5th held. Pop one → 5th accepted. Order preserved.
- Sequence 1B 5B 31 3B 35 48 → single UNKNOWN/0x48. Then 1B 78 → ALT/0x78. Then 1B 1B → one ESC, state remains S_ESC.
- Assert rst_n low asynchronously after 1B 5B with 2 events queued → ev_valid=0 immediately, busy=0. Then 0x41 → CHAR/0x41.
- With TERM_KEY_ESC_TIMEOUT_EN and TIMEOUT_CYCLES=8: 0x1B, then idle → EV_ESC after 8 cycles. Repeat with a byte accepted on the 8th cycle → no timeout event.
